// File: rtl/led_matrix_scanner.sv
// Scan driver for chained shift-register LED matrices: a double-buffered grey-scale frame is
// serialised row by row, with bit-plane brightness modulation and a per-frame horizontal scroll.
module led_matrix_scanner #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int GRAY_BITS = 2,
    parameter int CLK_DIV   = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [GRAY_BITS-1:0]    wr_data,
    input  logic                    swap_req,
    input  logic [$clog2(COLS)-1:0] scroll,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic                    serial_clk,
    output logic                    serial_data,
    output logic                    rclk,
    output logic                    clear
);
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOTS  = ROWS + COLS + 1;
    localparam int KW     = $clog2(SLOTS);
    localparam int PLANES = (1 << GRAY_BITS) - 1;

    localparam logic [DW-1:0]        DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [KW-1:0]        LATCH_K    = KW'(ROWS + COLS);
    localparam logic [KW-1:0]        FIRST_CATH = KW'(ROWS);
    localparam logic [RW-1:0]        ROW_LAST   = RW'(ROWS - 1);
    localparam logic [GRAY_BITS-1:0] PLANE_LAST = GRAY_BITS'(PLANES - 1);

    typedef enum logic {PH_SETUP, PH_CLOCK} phase_t;

    phase_t               phase, phase_next;
    logic [DW-1:0]        div_cnt;
    logic [KW-1:0]        bit_k;
    logic [RW-1:0]        row;
    logic [GRAY_BITS-1:0] plane;
    logic                 bank_sel;
    logic                 swap_pend;
    logic [CW-1:0]        scroll_l;
    logic [GRAY_BITS-1:0] mem [2][ROWS][COLS];

    logic                 tick, at_boundary, holding, frame_tick, shift_bit, wr_ok;
    logic [CW-1:0]        cath_col;
    logic [GRAY_BITS-1:0] pixel;

    always_comb begin
        tick        = (div_cnt == DIV_LAST);
        at_boundary = tick && (phase == PH_SETUP) && (bit_k == '0);
        holding     = at_boundary && !en;
        frame_tick  = at_boundary && en && (row == '0) && (plane == '0);
        phase_next  = phase;
        if (tick && !holding)
            phase_next = (phase == PH_SETUP) ? PH_CLOCK : PH_SETUP;
        // Wrapped modulo keeps the read index legal even while shifting anode bits.
        cath_col = CW'((((int'(bit_k) - ROWS + int'(scroll_l)) % COLS) + COLS) % COLS);
        pixel    = mem[bank_sel][row][cath_col];
        if (bit_k < FIRST_CATH)
            shift_bit = (int'(bit_k) == int'(row));
        else
            shift_bit = !(pixel > plane);
        wr_ok = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[~bank_sel][wr_row][wr_col] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= PH_SETUP;
            div_cnt     <= '0;
            bit_k       <= '0;
            row         <= '0;
            plane       <= '0;
            bank_sel    <= 1'b0;
            swap_pend   <= 1'b0;
            scroll_l    <= '0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            serial_clk  <= 1'b0;
            serial_data <= 1'b0;
            rclk        <= 1'b0;
            clear       <= 1'b0;
        end else begin
            clear       <= 1'b1;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            phase       <= phase_next;
            if (swap_req)
                swap_pend <= 1'b1;
            if (holding) begin
                serial_clk <= 1'b0;
                rclk       <= 1'b0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick && phase == PH_SETUP) begin
                    serial_clk <= 1'b0;
                    if (bit_k == LATCH_K) begin
                        rclk <= 1'b1;
                    end else begin
                        rclk        <= 1'b0;
                        serial_data <= shift_bit;
                    end
                    // A request arriving on the swap cycle merges into this swap.
                    if (frame_tick) begin
                        frame_start <= 1'b1;
                        scroll_l    <= scroll;
                        if (swap_pend) begin
                            bank_sel  <= ~bank_sel;
                            swap_ack  <= 1'b1;
                            swap_pend <= 1'b0;
                        end
                    end
                end else if (tick) begin
                    if (bit_k != LATCH_K) begin
                        serial_clk <= 1'b1;
                        bit_k      <= bit_k + 1'b1;
                    end else begin
                        bit_k <= '0;
                        if (row == ROW_LAST) begin
                            row   <= '0;
                            plane <= (plane == PLANE_LAST) ? '0 : plane + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner on a 4x4, 2-bit matrix: rows shifted out are captured
// as 8-bit words (bit k = k-th bit shifted) and compared with hand-computed patterns.
module tb_led_matrix_scanner;
    localparam int ROWS = 4, COLS = 4, GRAY_BITS = 2, CLK_DIV = 2;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, wr_en = 1'b0, swap_req = 1'b0;
    logic [1:0] wr_row = '0, wr_col = '0, wr_data = '0, scroll = '0;
    logic       swap_ack, frame_start, serial_clk, serial_data, rclk, clear;

    led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .GRAY_BITS(GRAY_BITS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .swap_req(swap_req), .scroll(scroll), .swap_ack(swap_ack),
        .frame_start(frame_start), .serial_clk(serial_clk), .serial_data(serial_data),
        .rclk(rclk), .clear(clear)
    );

    always #5 clk = ~clk;

    int n_compared = 0, n_mismatched = 0;
    int cyc = 0, bit_cnt = 0, rclk_run = 0, rclk_len = 0, cap_count = 0;
    int rise_cyc = 0, prev_rise_cyc = 0, fs_count = 0, fs_cyc = 0, prev_fs_cyc = 0, fs_cap_base = 0;
    int ack_count = 0;
    logic ack_with_fs = 1'b0, prev_sclk = 1'b0, prev_rclk = 1'b0;
    logic [7:0] shift_word = '0;
    logic [7:0] cap_word [256];
    int         cap_bits [256];

    // Reconstruct each latched row from the serial pins, just after every active edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            bit_cnt = 0; shift_word = '0; prev_sclk = 1'b0; prev_rclk = 1'b0; rclk_run = 0;
        end else begin
            if (serial_clk && !prev_sclk) begin
                if (bit_cnt < 8) shift_word[bit_cnt] = serial_data;
                bit_cnt++;
            end
            if (rclk && !prev_rclk && cap_count < 256) begin
                cap_word[cap_count] = shift_word;
                cap_bits[cap_count] = bit_cnt;
                cap_count++;
                prev_rise_cyc = rise_cyc;
                rise_cyc = cyc;
                bit_cnt = 0;
            end
            if (rclk) rclk_run++;
            else if (prev_rclk) begin rclk_len = rclk_run; rclk_run = 0; end
            if (frame_start) begin
                fs_count++; prev_fs_cyc = fs_cyc; fs_cyc = cyc; fs_cap_base = cap_count;
            end
            if (swap_ack) begin ack_count++; ack_with_fs = frame_start; end
            prev_sclk = serial_clk;
            prev_rclk = rclk;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int r, input int c, input int d);
        wr_row = 2'(r); wr_col = 2'(c); wr_data = 2'(d); wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic wait_frame();
        int n0 = fs_count;
        int t = 0;
        while (fs_count == n0 && t < 1000) begin @(negedge clk); t++; end
        if (fs_count == n0) check_output("frame_timeout", 0, 1);
    endtask

    task automatic wait_caps(input int n);
        int t = 0;
        while (cap_count < n && t < 2000) begin @(negedge clk); t++; end
        if (cap_count < n) check_output("capture_timeout", cap_count, n);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got stuck, want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base, ack_before, highs, t, target;
        repeat (3) @(negedge clk);
        check_output("reset_outputs", {26'd0, serial_clk, serial_data, rclk, clear, swap_ack, frame_start}, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                apply_stimulus(r, c, 0);

        rst_n = 1'b1; swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        check_output("clear_after_release", clear, 1);
        check_output("no_early_frame_start", frame_start, 0);
        @(negedge clk);
        check_output("first_frame_start", frame_start, 1);
        check_output("first_swap_ack", swap_ack, 1);

        base = fs_cap_base;
        wait_caps(base + 2);
        check_output("row_period", rise_cyc - prev_rise_cyc, 36);
        check_output("row0_blank", cap_word[base], 8'hF1);
        check_output("row0_bits", cap_bits[base], 8);
        check_output("row1_blank", cap_word[base + 1], 8'hF2);
        repeat (6) @(negedge clk);
        check_output("rclk_width", rclk_len, 4);

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                apply_stimulus(r, c, (r == 1 && c == 2) ? 3 : ((r == 1 && c == 3) ? 1 : 0));
        pulse_swap();

        wait_frame();
        check_output("frame_period", fs_cyc - prev_fs_cyc, 432);
        check_output("swap_ack_count_f2", ack_count, 2);
        scroll = 2'd1;
        base = fs_cap_base;
        wait_caps(base + 12);
        check_output("pat_row0_p0", cap_word[base], 8'hF1);
        check_output("pat_row1_p0", cap_word[base + 1], 8'h32);
        check_output("pat_row1_p1", cap_word[base + 5], 8'hB2);
        check_output("pat_row1_p2", cap_word[base + 9], 8'hB2);

        wait_frame();
        scroll = 2'd0;
        ack_before = ack_count;
        base = fs_cap_base;
        repeat (10) @(negedge clk);
        pulse_swap();
        repeat (20) @(negedge clk);
        pulse_swap();
        wait_caps(base + 12);
        check_output("scroll_row1_p0", cap_word[base + 1], 8'h92);
        check_output("scroll_row1_p1", cap_word[base + 5], 8'hD2);
        check_output("no_swap_midframe", ack_count - ack_before, 0);

        target = fs_cyc + 431;
        t = 0;
        while (cyc < target && t < 1000) begin @(negedge clk); t++; end
        apply_stimulus(2, 0, 3);
        check_output("swap_at_frame_start", fs_cyc, target + 1);
        check_output("single_swap_ack", ack_count - ack_before, 1);
        check_output("ack_with_frame_start", ack_with_fs, 1);
        base = fs_cap_base;
        wait_caps(base + 12);
        check_output("swapped_row1", cap_word[base + 1], 8'hF2);
        check_output("swap_cycle_write", cap_word[base + 2], 8'hE4);
        check_output("still_one_ack", ack_count - ack_before, 1);

        wait_frame();
        base = fs_cap_base;
        wait_caps(base + 2);
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_caps(base + 3);
        check_output("row2_completes", cap_word[base + 2], 8'hE4);
        repeat (10) @(negedge clk);
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (serial_clk || rclk) highs++;
        end
        check_output("hold_quiet", highs, 0);
        check_output("hold_no_capture", cap_count, base + 3);
        en = 1'b1;
        wait_caps(base + 4);
        check_output("resume_row3", cap_word[base + 3], 8'hF8);
        check_output("resume_row3_bits", cap_bits[base + 3], 8);

        t = 0;
        while (bit_cnt < 5 && t < 500) begin @(negedge clk); t++; end
        check_output("reached_cathodes", (bit_cnt >= 5) ? 1 : 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midrow_reset_outputs", {26'd0, serial_clk, serial_data, rclk, clear, swap_ack, frame_start}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("restart_no_early_fs", frame_start, 0);
        @(negedge clk);
        check_output("restart_frame_start", frame_start, 1);
        base = fs_cap_base;
        wait_caps(base + 1);
        check_output("restart_row0", cap_word[base], 8'hF1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Parametrised scan driver for shift-register LED matrices (chained 74HC595-style anode/cathode registers). It holds a double-buffered ROWS×COLS grey-scale frame and serialises one row at a time through a shared shift chain. Brightness comes from binary-threshold bit-plane modulation, and a per-frame horizontal scroll offset is applied. It sits between the pixel producer (pattern or waveform generator writing via the write port) and the board's matrix connector pins.

## Interface
Parameters:
- ROWS, 16, matrix rows (anode bits), ≥2
- COLS, 16, matrix columns (cathode bits), ≥2
- GRAY_BITS, 2, bits per pixel; 2^GRAY_BITS−1 planes per frame
- CLK_DIV, 100, clk cycles per tick (half serial period), ≥1

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  scan enable; sampled at row boundaries
- wr_en  in  1  write strobe into back buffer
- wr_row  in  $clog2(ROWS)  write row address
- wr_col  in  $clog2(COLS)  write column address
- wr_data  in  GRAY_BITS  pixel intensity, 0 = off
- swap_req  in  1  request front/back swap at next frame boundary
- scroll  in  $clog2(COLS)  column offset, sampled per frame
- swap_ack  out  1  one-clk pulse when swap takes effect
- frame_start  out  1  one-clk pulse at start of each frame
- serial_clk  out  1  shift clock to chain
- serial_data  out  1  shift data
- rclk  out  1  storage-register latch
- clear  out  1  chain clear, active-low

## Operation
- Tick: divider counts 0..CLK_DIV−1; tick on CLK_DIV−1. Ticks alternate setup/clock. First tick after reset is a setup tick.
- Setup tick: serial_clk←0, serial_data←next bit (or rclk←1 in latch slot). Clock tick: serial_clk←1 (in latch slot serial_clk stays 0, rclk stays 1).
- Row slot sequence: ROWS anode bits, then COLS cathode bits, then 1 latch slot. Bit k=0 is shifted first.
- Anode bit i = 1 iff i == current row r.
- Cathode bit c = 0 (LED on) iff front[r][(c+scroll_l) mod COLS] > p; else 1. Here p is the current plane 0..2^GRAY_BITS−2 and scroll_l is the latched scroll.
- Order: rows 0..ROWS−1 inside planes 0..2^GRAY_BITS−2. After the last plane, a new frame begins.
- Frame boundary = setup tick of plane 0, row 0, bit 0. At this tick: frame_start=1; scroll latched; if a swap is pending, banks exchange, swap_ack=1, and pending clears.
- swap_req while a swap is already pending: merged (single swap).
- Writes go to the back bank in any cycle. On the swap cycle, a write targets the pre-swap back bank (which becomes front). Out-of-range wr_row/wr_col are ignored.
- en low at a row boundary (setup tick that would start bit 0 of a row): hold. The divider is frozen, serial_clk=0, rclk=0, and row/plane are kept. When en returns high, scanning resumes at that row. en changes mid-row have no effect until the next boundary.
- Buffer contents are not reset.

## Timing
- Reset values: serial_clk 0, serial_data 0, rclk 0, clear 0, swap_ack 0, frame_start 0. Counters, row, plane and bank select are 0; no swap is pending; scroll_l is 0.
- clear goes 1 on the first clk after rst_n=1 and stays 1.
- First tick is CLK_DIV clk cycles after reset release, and is a frame boundary (frame_start pulses).
- Bit period = 2·CLK_DIV clk. Row period = (ROWS+COLS+1)·2·CLK_DIV clk. Frame = (2^GRAY_BITS−1)·ROWS·row period.
- serial_data is stable for the full 2·CLK_DIV window around each serial_clk rising edge. rclk is high for exactly 2·CLK_DIV clk with serial_clk low.
- A write is visible to scanning only after a subsequent swap. swap_req to swap_ack latency is at most 1 frame plus 1 tick.
- Reset mid-row: all outputs return to reset values on the next clk and the scan restarts at frame start.

## Test plan
Parameters for all cases: ROWS=4, COLS=4, GRAY_BITS=2, CLK_DIV=2.

- Reset release, en=1, all pixels 0 after a swap: row 0 shifts anode 1000 then cathode 1111. rclk is high for 4 clk. Row period is 36 clk, frame is 432 clk, and frame_start pulses every 432 clk.
- Pixel [1][2]=3, [1][3]=1, swapped: in row 1, plane 0 cathode is 1100, plane 1 is 1101, plane 2 is 1101.
- Same frame with scroll=1: row 1 cathode for plane 0 is 1001. A scroll change mid-frame has no effect until the next frame_start.
- swap_req pulsed twice mid-frame: exactly one swap_ack, coincident with the next frame_start. A write issued in the same cycle as the swap appears in the following frame.
- en low mid-row 2: row 2 completes (latch included), then serial_clk/rclk are held 0. After en returns high, the next bit shifted is bit 0 of row 3.
- rst_n low during the cathode bits: next clk gives clear=0 and serial_clk=0. After release, the scan restarts with frame_start after 2 clk.
